seg_scan: RTL and testbench
===========================

Name: seg_scan

Overview:
- Downstream consumer of the 4-bit captured nibbles produced by the dual-clock data capture stage.
- Latches four 4-bit digit values on a load strobe and time-multiplexes them onto a 4-digit common-anode 7-segment display.
- Provides hex decoding, per-digit decimal points, optional leading-zero blanking, and a one-cycle anti-ghosting dead time at every digit change.
- Single clock domain; sits between the data capture stage and the board display pins.

Parameters:
DIV, 50000, clock cycles per digit slot (1 kHz digit rate at 50 MHz); legal range 2..2^20.
CW, 20, refresh counter width; must satisfy 2^CW >= DIV.

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  asynchronous, active-low reset.
d0  input  4  digit 0 value (rightmost, least significant).
d1  input  4  digit 1 value.
d2  input  4  digit 2 value.
d3  input  4  digit 3 value (leftmost).
dp  input  4  decimal point enables; bit i belongs to digit i; 1 = lit.
load  input  1  when 1 at a clk edge, d0..d3 and dp are captured into shadow registers.
blank_lz  input  1  1 = blank leading zeros.
an  output  4  anode enables, active-low; bit i drives digit i.
seg  output  7  segments, active-low, bit6..bit0 = g,f,e,d,c,b,a.
dpo  output  1  decimal point segment, active-low.

Behaviour:
- Reset is asynchronous, active-low. While rst=0: cnt=0, idx=0, shadow digits=0, shadow dp=0, an=4'b1111, seg=7'h7F, dpo=1.
- Shadow load: on an edge with load=1, shadow digits and shadow dp take d0..d3 and dp. Otherwise they hold. Inputs are never used directly for display.
- Refresh counter cnt runs 0..DIV-1 and wraps to 0. idx (2 bits) increments 0->1->2->3->0 on the edge where cnt==DIV-1.
- Outputs are registered. At each edge, an, seg and dpo load values computed from the cnt, idx and shadow state present before that edge.
- Dead cycle: when the pre-edge cnt==0, an loads 4'b1111, seg loads 7'h7F and dpo loads 1.
- Active cycles: otherwise an loads the one-hot-low code of idx (idx 0 -> 4'b1110, idx 3 -> 4'b0111). seg loads decode(shadow[idx]) and dpo loads ~shadow_dp[idx].
- Each digit is therefore lit for DIV-1 of every DIV cycles.
- Decode, hex, active-low, gfedcba:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Leading-zero blanking applies only when blank_lz=1:
  - digit3 is blanked if shadow d3==0.
  - digit2 is blanked if d3==0 and d2==0.
  - digit1 is blanked if d3, d2 and d1 are all 0.
  - digit0 is never blanked.
  - A blanked digit gives seg=7'h7F, but its anode still strobes and dpo still follows dp.
- Simultaneous load and counter wrap: both take effect on the same edge. The new idx displays the new shadow data from the next active cycle.
- Load latency: new data appears on seg no later than 2 edges after the load edge, if the current slot is the affected digit.
- blank_lz is sampled live; it is not shadowed.
- Reset asserted mid-scan: outputs go to reset values immediately, without waiting for clk. After release, the scan restarts at idx 0 with a dead cycle.

Test Plan:
- Reset: hold rst=0 for 3 cycles with d* and dp nonzero -> an=1111, seg=7F, dpo=1 throughout. After release (DIV=4), the first edge gives an=1111, and the next 3 edges give an=1110, seg=40.
- Scan order (DIV=4): load d3..d0=1,2,3,4, dp=0 -> repeating 16-cycle pattern: per slot 1 dead cycle (an=1111) then 3 cycles of (1110,19), (1101,30), (1011,24), (0111,79). dpo=1 throughout.
- Leading-zero blanking: load d3..d0=0,0,0,7, blank_lz=1 -> digits 3/2/1 seg=7F with anodes still strobing, digit0 seg=78. Repeat with blank_lz=0 -> digits 3/2/1 seg=40.
- All-zero with blank_lz=1 -> digits 3..1 seg=7F, digit0 seg=40. Separately, d3..d0=0,5,0,0 -> only digit3 blanked; digit1 and digit0 show 40.
- Hex and dp: load d3..d0=A,b,E,F, dp=4'b0101 -> seg 08/03/06/0E in slot order 3..0 (0E on idx0, 08 on idx3). dpo=0 during the idx0 and idx2 active cycles, 1 otherwise.
- Load during a slot plus mid-scan reset: load d0 from 4 to 9 during the idx0 active cycles -> seg becomes 10 within 2 edges. Then pull rst low mid-slot -> an=1111, seg=7F in the same cycle without a clk edge, and shadow data reads 0 after release.

Source files
------------

// File: rtl/seg_scan.sv
// Four-digit common-anode 7-segment scanner: shadows digit/dp values on load,
// multiplexes them with hex decode, leading-zero blanking and a dead cycle per slot.
module seg_scan #(
   parameter int unsigned DIV = 50000,
   parameter int unsigned CW  = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic [3:0] dp,
   input  logic       load,
   input  logic       blank_lz,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dpo
);

   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   logic [CW-1:0]   cnt;
   logic [1:0]      idx;
   logic [3:0][3:0] sd;
   logic [3:0]      sdp;

   logic [3:0] cur_c;
   logic       lz_c;
   logic [3:0] an_c;
   logic [6:0] seg_c;
   logic       dpo_c;

   // Hex to active-low gfedcba
   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'h0: decode = 7'h40;
         4'h1: decode = 7'h79;
         4'h2: decode = 7'h24;
         4'h3: decode = 7'h30;
         4'h4: decode = 7'h19;
         4'h5: decode = 7'h12;
         4'h6: decode = 7'h02;
         4'h7: decode = 7'h78;
         4'h8: decode = 7'h00;
         4'h9: decode = 7'h10;
         4'hA: decode = 7'h08;
         4'hB: decode = 7'h03;
         4'hC: decode = 7'h46;
         4'hD: decode = 7'h21;
         4'hE: decode = 7'h06;
         default: decode = 7'h0E;
      endcase
   endfunction

   // Next output values from the pre-edge scan position and shadow state
   always_comb begin
      cur_c = sd[idx];
      lz_c  = 1'b0;
      an_c  = 4'b1111;
      seg_c = 7'h7F;
      dpo_c = 1'b1;
      case (idx)
         2'd3:    lz_c = (sd[3] == 4'h0);
         2'd2:    lz_c = (sd[3] == 4'h0) && (sd[2] == 4'h0);
         2'd1:    lz_c = (sd[3] == 4'h0) && (sd[2] == 4'h0) && (sd[1] == 4'h0);
         default: lz_c = 1'b0;
      endcase
      if (cnt != '0) begin
         an_c  = ~(4'b0001 << idx);
         seg_c = (blank_lz && lz_c) ? 7'h7F : decode(cur_c);
         dpo_c = ~sdp[idx];
      end
   end

   // Refresh counter, slot index and shadow registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         idx <= 2'd0;
         sd  <= '0;
         sdp <= 4'h0;
      end else begin
         if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end
         if (load) begin
            sd  <= {d3, d2, d1, d0};
            sdp <= dp;
         end
      end
   end

   // Registered display drive
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an  <= 4'b1111;
         seg <= 7'h7F;
         dpo <= 1'b1;
      end else begin
         an  <= an_c;
         seg <= seg_c;
         dpo <= dpo_c;
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan (DIV=4): a reference model pushes expected
// outputs per edge into a queue; they are popped and compared after the edge.
module tb_seg_scan;

   localparam int DIV = 4;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dpo;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0, dp = '0;
   logic       load = 1'b0;
   logic       blank_lz = 1'b0;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dpo;

   int vectors = 0;
   int miscompares = 0;

   exp_t q[$];

   logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference state
   int         m_cnt = 0;
   int         m_idx = 0;
   logic [3:0] m_d [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
   logic [3:0] m_dp = 4'h0;

   seg_scan #(.DIV(DIV), .CW(2)) dut (
      .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .dp(dp),
      .load(load), .blank_lz(blank_lz), .an(an), .seg(seg), .dpo(dpo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_idx = 0;
      for (int i = 0; i < 4; i++) m_d[i] = 4'h0;
      m_dp = 4'h0;
   endtask

   // One clock edge: predict, advance model, compare after the edge
   task automatic step();
      exp_t e;
      exp_t got;
      logic blank;
      blank = 1'b0;
      if (m_cnt == 0) begin
         e.an = 4'b1111; e.seg = 7'h7F; e.dpo = 1'b1;
      end else begin
         case (m_idx)
            3: blank = (m_d[3] == 0);
            2: blank = (m_d[3] == 0) && (m_d[2] == 0);
            1: blank = (m_d[3] == 0) && (m_d[2] == 0) && (m_d[1] == 0);
            default: blank = 1'b0;
         endcase
         e.an  = 4'b1111;
         e.an[m_idx] = 1'b0;
         e.seg = (blank_lz && blank) ? 7'h7F : dec[m_d[m_idx]];
         e.dpo = ~m_dp[m_idx];
      end
      q.push_back(e);
      if (load) begin
         m_d[0] = d0; m_d[1] = d1; m_d[2] = d2; m_d[3] = d3;
         m_dp = dp;
      end
      if (m_cnt == DIV - 1) begin
         m_cnt = 0;
         m_idx = (m_idx + 1) % 4;
      end else begin
         m_cnt++;
      end
      @(posedge clk);
      #1;
      got = q.pop_front();
      chk($sformatf("an idx%0d", got.an == 4'b1111 ? -1 : m_idx), {3'b000, an}, {3'b000, got.an});
      chk("seg", seg, got.seg);
      chk("dpo", {6'b0, dpo}, {6'b0, got.dpo});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_load(input logic [3:0] v3, v2, v1, v0, input logic [3:0] p);
      d3 = v3; d2 = v2; d1 = v1; d0 = v0; dp = p;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      // Reset held with nonzero inputs
      d3 = 4'h1; d2 = 4'h2; d1 = 4'h3; d0 = 4'h4; dp = 4'hF; load = 1'b1;
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst an", {3'b000, an}, 7'h0F);
         chk("rst seg", seg, 7'h7F);
         chk("rst dpo", {6'b0, dpo}, 7'h01);
      end
      load = 1'b0;
      rst = 1'b1;
      model_reset();
      run(4);

      // Scan order
      do_load(4'h1, 4'h2, 4'h3, 4'h4, 4'h0);
      run(32);

      // Leading-zero blanking on and off
      blank_lz = 1'b1;
      do_load(4'h0, 4'h0, 4'h0, 4'h7, 4'h0);
      run(16);
      blank_lz = 1'b0;
      run(16);

      // All zero blanked, then interior zeros kept
      blank_lz = 1'b1;
      do_load(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      run(16);
      do_load(4'h0, 4'h5, 4'h0, 4'h0, 4'h0);
      run(16);
      blank_lz = 1'b0;

      // Hex letters and decimal points
      do_load(4'hA, 4'hB, 4'hE, 4'hF, 4'b0101);
      run(16);

      // Reload d0 while digit 0 is on
      do_load(4'h1, 4'h2, 4'h3, 4'h4, 4'h0);
      for (int i = 0; i < 16 && !(m_idx == 0 && m_cnt == 1); i++) step();
      do_load(4'h1, 4'h2, 4'h3, 4'h9, 4'h0);
      step();
      chk("reload seg", seg, 7'h10);
      run(6);

      // Asynchronous reset mid-slot
      #2 rst = 1'b0;
      #1;
      chk("async an", {3'b000, an}, 7'h0F);
      chk("async seg", seg, 7'h7F);
      chk("async dpo", {6'b0, dpo}, 7'h01);
      @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      run(16);
      chk("queue empty", 7'(q.size()), 7'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
